// File: rtl/sum_latch_pkg.sv
// Shared types and helpers for the operand-summing UART reporter.
// Holds the serializer state encoding and a constant-friendly ceil(log2).
package sum_latch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = int'(i) + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready is high when idle and in the last stop-bit cycle,
// so a start accepted there chains the next byte with no idle gap.
module uart_tx_byte
  import sum_latch_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CntW = clog2(CLKS_PER_BIT);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ready   = 1'b0;
    txd     = 1'b1;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          shreg_d = data;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        txd = shreg_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) state_d = StStop;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          ready = 1'b1;
          cnt_d = '0;
          if (start) begin
            shreg_d = data;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/sum_latch_uart_n.sv
// Latches operands on asynchronous save strobes, sums (or differences) them once
// every slot is fresh, and reports the snapshot over UART, LSB byte first.
module sum_latch_uart_n
  import sum_latch_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned NUM_OPS      = 2,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  data_input,
  input  logic [NUM_OPS-1:0] save_n,
  input  logic               mode,
  output logic               uart_txd,
  output logic               uart_tx_busy,
  output logic [NUM_OPS-1:0] ops_valid
);

  localparam int unsigned RES_W  = DATA_W + clog2(NUM_OPS);
  localparam int unsigned NBYTES = (RES_W + 7) / 8;
  localparam int unsigned PadW   = NBYTES * 8;
  localparam int unsigned IdxW   = clog2(NBYTES + 1);

  logic [NUM_OPS-1:0] save_s1_q, save_s1_d, save_s2_q, save_s2_d;
  logic [NUM_OPS-1:0] save_prev_q, save_prev_d, armed_q, armed_d;
  logic               live_q, live_d;
  logic [DATA_W-1:0]  data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic [DATA_W-1:0]  ops_q [NUM_OPS];
  logic [DATA_W-1:0]  ops_d [NUM_OPS];
  logic [NUM_OPS-1:0] valid_q, valid_d;
  logic [RES_W-1:0]   snap_q, snap_d;
  logic               busy_q, busy_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  logic [NUM_OPS-1:0] save_evt;
  logic [RES_W-1:0]   result;
  logic [PadW-1:0]    snap_pad;
  logic               launch, tx_start, tx_ready;
  logic [7:0]         tx_data;

  // A slot only arms after a genuine high sample, so a strobe held low across
  // reset release cannot masquerade as a falling edge.
  assign save_evt = armed_q & save_prev_q & ~save_s2_q;
  assign launch   = (&valid_q) & ~busy_q;
  assign snap_pad = PadW'(snap_q);

  always_comb begin
    result = '0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      if (mode && i != 0) result = result - RES_W'(ops_q[i]);
      else result = result + RES_W'(ops_q[i]);
    end
  end

  always_comb begin
    save_s1_d   = save_n;
    save_s2_d   = save_s1_q;
    save_prev_d = save_s2_q;
    live_d      = 1'b1;
    armed_d     = armed_q | (save_s1_q & {NUM_OPS{live_q}});
    data_s1_d   = data_input;
    data_s2_d   = data_s1_q;

    ops_d = ops_q;
    for (int k = 0; k < int'(NUM_OPS); k++) begin
      if (save_evt[k]) ops_d[k] = data_s2_q;
    end
    valid_d = (launch ? '0 : valid_q) | save_evt;
    snap_d  = launch ? result : snap_q;

    busy_d   = busy_q;
    idx_d    = idx_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    if (launch) begin
      busy_d   = 1'b1;
      idx_d    = IdxW'(1);
      tx_start = 1'b1;
      tx_data  = 8'(result);
    end else if (busy_q && tx_ready) begin
      if (idx_q == IdxW'(NBYTES)) begin
        busy_d = 1'b0;
      end else begin
        tx_start = 1'b1;
        idx_d    = idx_q + IdxW'(1);
        for (int b = 0; b < int'(NBYTES); b++) begin
          if (idx_q == IdxW'(b)) tx_data = snap_pad[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      save_s1_q   <= '1;
      save_s2_q   <= '1;
      save_prev_q <= '1;
      armed_q     <= '0;
      live_q      <= 1'b0;
      data_s1_q   <= '1;
      data_s2_q   <= '1;
      for (int k = 0; k < int'(NUM_OPS); k++) ops_q[k] <= '0;
      valid_q     <= '0;
      snap_q      <= '0;
      busy_q      <= 1'b0;
      idx_q       <= '0;
    end else begin
      save_s1_q   <= save_s1_d;
      save_s2_q   <= save_s2_d;
      save_prev_q <= save_prev_d;
      armed_q     <= armed_d;
      live_q      <= live_d;
      data_s1_q   <= data_s1_d;
      data_s2_q   <= data_s2_d;
      ops_q       <= ops_d;
      valid_q     <= valid_d;
      snap_q      <= snap_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (tx_start),
    .data   (tx_data),
    .ready  (tx_ready),
    .txd    (uart_txd)
  );

  assign uart_tx_busy = busy_q;
  assign ops_valid    = valid_q;

endmodule

// File: doc/sum_latch_uart_n.md
SUM_LATCH_UART_N -- requirements
Module: sum_latch_uart_n

Interface
REQ-001 Parameter DATA_W, default 4, operand width in bits (1..16).
REQ-002 Parameter NUM_OPS, default 2, number of operand slots (2..8).
REQ-003 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (>=4).
REQ-004 Derived RES_W = DATA_W + clog2(NUM_OPS); NBYTES = ceil(RES_W/8).
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 data_input  input  DATA_W  operand value, asynchronous to clk.
REQ-008 save_n  input  NUM_OPS  active-low save strobes, one per slot, asynchronous.
REQ-009 mode  input  1  0 = sum of all operands; 1 = op0 minus the sum of op1..opN-1; sampled at frame launch.
REQ-010 uart_txd  output  1  8N1 serial output, idle high.
REQ-011 uart_tx_busy  output  1  high while a result is being transmitted.
REQ-012 ops_valid  output  NUM_OPS  per-slot "saved since last launch" flags.

Function
REQ-013 Each save_n bit and data_input SHALL pass a 2-flop synchronizer; a save event is a synchronized high-to-low transition.
REQ-014 On a save event for slot k, operand k SHALL load the synchronized data_input and ops_valid[k] SHALL set, exactly 3 clk edges after save_n is first sampled low.
REQ-015 Simultaneous save events on several slots SHALL load all of those slots with the same value in the same cycle.
REQ-016 A held-low save_n SHALL produce one save event only.
REQ-017 A save event for an already-valid slot SHALL overwrite that operand.
REQ-018 Launch SHALL occur in the first cycle where all ops_valid bits are 1 and the transmitter is idle. At launch: the result is computed from the current operands and mode into a RES_W-bit snapshot register, and all ops_valid bits clear.
REQ-019 Arithmetic SHALL be unsigned modulo 2^RES_W; mode 1 wraps as two's complement in RES_W bits.
REQ-020 A save event in the launch cycle SHALL load its operand and leave its ops_valid bit set for the next result.
REQ-021 Saves during transmission SHALL update operands only; the snapshot SHALL be unaffected.
REQ-022 The snapshot SHALL be sent as NBYTES bytes, least-significant byte first. Bits above RES_W in the top byte SHALL be 0.
REQ-023 Each byte SHALL be framed as start (0), 8 data bits LSB first, stop (1), each bit lasting exactly CLKS_PER_BIT cycles. Consecutive bytes SHALL be back-to-back with no idle gap.
REQ-024 The transmit FSM SHALL have states IDLE, START, DATA, STOP. STOP advances to START if bytes remain, else to IDLE.
REQ-025 uart_txd SHALL go low and uart_tx_busy high on the cycle after launch. uart_tx_busy SHALL fall on the cycle after the final stop bit completes.
REQ-026 If all slots become valid again during a transmission, launch SHALL occur on the cycle busy falls (zero idle).

Reset
REQ-027 While reset_n is low at a rising edge: uart_txd=1, uart_tx_busy=0, ops_valid=0, operands=0, snapshot=0, FSM=IDLE, counters=0, synchronizers=1 (idle).
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no partial byte resumes after release.
REQ-029 A save_n held low across reset release SHALL NOT generate a save event.

Structure
REQ-030 Package sum_latch_pkg SHALL hold the tx state enum and the clog2 function; RES_W/NBYTES are derived locally.
REQ-031 Byte serialization SHALL be a sub-module uart_tx_byte (CLKS_PER_BIT parameter; start/ready handshake; txd output).
REQ-032 Operand latching, arithmetic, launch and byte sequencing SHALL live in sum_latch_uart_n.

Verification (DATA_W=4, NUM_OPS=2, CLKS_PER_BIT=8 unless stated)
REQ-033 save slot0 with 0x9, slot1 with 0x7, mode 0 -> one frame with byte 0x10. txd sequence 0,0,0,0,0,1,0,0,0,1; each bit 8 cycles; busy high for exactly 80 cycles.
REQ-034 mode 1, op0=0x3, op1=0x5 -> byte 0x1E (-2 mod 32).
REQ-035 DATA_W=8, NUM_OPS=4; operands 0xFF x4 -> result 0x3FC sent as 0xFC then 0x03 back-to-back; busy 160 cycles.
REQ-036 Re-save both slots (0x1, 0x2) mid-frame of the REQ-033 case -> the first frame is unchanged (0x10); 0x03 starts the cycle busy falls.
REQ-037 Assert reset_n low during DATA bit 3 -> txd=1, busy=0, ops_valid=0 the next cycle. With save_n held low through release, no frame is sent.
REQ-038 Both save_n fall together with data 0x4 -> both slots load 0x4 in the same cycle; result 0x08 is sent.
